// File: rtl/bullet_scheduler.sv
// Two-tank bullet slot scheduler: edge-detected shoot requests, round-robin
// arbitration, per-tank cooldown and ammo limits, and four timed bullet slots.
module bullet_scheduler #(
   parameter logic [9:0] LIFETIME     = 10'd300,
   parameter logic [5:0] COOLDOWN     = 6'd20,
   parameter logic [2:0] MAX_PER_TANK = 3'd2
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       Shoot1,
   input  logic       Shoot2,
   input  logic [5:0] Angle1,
   input  logic [5:0] Angle2,
   input  logic [3:0] Kill,
   output logic       Launch,
   output logic [1:0] LaunchSlot,
   output logic       LaunchOwner,
   output logic [5:0] LaunchAngle,
   output logic [3:0] SlotActive,
   output logic [3:0] SlotOwner,
   output logic [1:0] Ammo1,
   output logic [1:0] Ammo2
);

   localparam int unsigned NSLOT = 4;
   localparam int unsigned NTANK = 2;

   logic [1:0]       r_prev;
   logic [1:0]       r_arm;
   logic [1:0]       r_pend;
   logic             r_prio;
   logic [1:0][5:0]  r_cool;
   logic [3:0][9:0]  r_life;

   logic [1:0]       w_shoot;
   logic [1:0]       w_rise;
   logic [1:0]       w_elig;
   logic [1:0]       w_pend_nxt;
   logic [1:0][2:0]  w_cnt;
   logic [1:0][2:0]  w_cnt_nxt;
   logic [1:0][5:0]  w_cool_nxt;
   logic [3:0][9:0]  w_life_nxt;
   logic [3:0]       w_act_nxt;
   logic [3:0]       w_own_nxt;
   logic [1:0]       w_slot;
   logic             w_any_free;
   logic             w_grant;
   logic             w_win;

   assign w_shoot = {Shoot2, Shoot1};

   always_comb begin
      // A rise only counts once Shoot has been seen low since reset
      w_rise     = w_shoot & ~r_prev & r_arm;
      w_any_free = ~&SlotActive;
      w_slot     = 2'd0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!SlotActive[i]) w_slot = 2'(i);
      end

      w_cnt = '0;
      for (int t = 0; t < NTANK; t++) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (SlotActive[i] && (SlotOwner[i] == 1'(t))) w_cnt[t] = w_cnt[t] + 3'd1;
         end
         w_elig[t] = r_pend[t] && (r_cool[t] == 6'd0) && (w_cnt[t] < MAX_PER_TANK) && w_any_free;
      end

      w_grant = |w_elig;
      w_win   = (&w_elig) ? r_prio : w_elig[1];

      // Lost-contention tanks keep pending; ineligible ones are dropped
      for (int t = 0; t < NTANK; t++) begin
         w_pend_nxt[t] = (r_pend[t] && w_elig[t] && !(w_grant && (w_win == 1'(t)))) || w_rise[t];
         if (w_grant && (w_win == 1'(t)))   w_cool_nxt[t] = COOLDOWN;
         else if (r_cool[t] != 6'd0)        w_cool_nxt[t] = r_cool[t] - 6'd1;
         else                               w_cool_nxt[t] = r_cool[t];
      end

      for (int i = 0; i < NSLOT; i++) begin
         w_act_nxt[i]  = SlotActive[i];
         w_own_nxt[i]  = SlotOwner[i];
         w_life_nxt[i] = r_life[i];
         if (SlotActive[i]) begin
            if (Kill[i] || (r_life[i] == 10'd1)) begin
               w_act_nxt[i]  = 1'b0;
               w_life_nxt[i] = 10'd0;
            end else begin
               w_life_nxt[i] = r_life[i] - 10'd1;
            end
         end
         if (w_grant && (w_slot == 2'(i))) begin
            w_act_nxt[i]  = 1'b1;
            w_own_nxt[i]  = w_win;
            w_life_nxt[i] = LIFETIME;
         end
      end

      w_cnt_nxt = '0;
      for (int t = 0; t < NTANK; t++) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (w_act_nxt[i] && (w_own_nxt[i] == 1'(t))) w_cnt_nxt[t] = w_cnt_nxt[t] + 3'd1;
         end
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_prev      <= '0;
         r_arm       <= '0;
         r_pend      <= '0;
         r_prio      <= 1'b0;
         r_cool      <= '0;
         r_life      <= '0;
         Launch      <= 1'b0;
         LaunchSlot  <= 2'd0;
         LaunchOwner <= 1'b0;
         LaunchAngle <= 6'd0;
         SlotActive  <= 4'd0;
         SlotOwner   <= 4'd0;
         Ammo1       <= 2'(MAX_PER_TANK);
         Ammo2       <= 2'(MAX_PER_TANK);
      end else begin
         r_prev     <= w_shoot;
         r_arm      <= r_arm | ~w_shoot;
         r_pend     <= w_pend_nxt;
         r_cool     <= w_cool_nxt;
         r_life     <= w_life_nxt;
         SlotActive <= w_act_nxt;
         SlotOwner  <= w_own_nxt;
         Ammo1      <= 2'(MAX_PER_TANK - w_cnt_nxt[0]);
         Ammo2      <= 2'(MAX_PER_TANK - w_cnt_nxt[1]);
         Launch     <= w_grant;
         if (w_grant) begin
            r_prio      <= ~w_win;
            LaunchSlot  <= w_slot;
            LaunchOwner <= w_win;
            LaunchAngle <= w_win ? Angle2 : Angle1;
         end
      end
   end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: launch latency, arbitration, cooldown,
// ammo limit, kill, lifetime expiry and reset behaviour.
module tb_bullet_scheduler;

   logic       frame_clk;
   logic       Reset;
   logic       Shoot1, Shoot2;
   logic [5:0] Angle1, Angle2;
   logic [3:0] Kill;
   logic       Launch;
   logic [1:0] LaunchSlot;
   logic       LaunchOwner;
   logic [5:0] LaunchAngle;
   logic [3:0] SlotActive;
   logic [3:0] SlotOwner;
   logic [1:0] Ammo1, Ammo2;

   int n_cmp;
   int n_bad;
   int edge_no;
   int g0;
   logic seen;

   bullet_scheduler dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .Shoot1     (Shoot1),
      .Shoot2     (Shoot2),
      .Angle1     (Angle1),
      .Angle2     (Angle2),
      .Kill       (Kill),
      .Launch     (Launch),
      .LaunchSlot (LaunchSlot),
      .LaunchOwner(LaunchOwner),
      .LaunchAngle(LaunchAngle),
      .SlotActive (SlotActive),
      .SlotOwner  (SlotOwner),
      .Ammo1      (Ammo1),
      .Ammo2      (Ammo2)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      edge_no++;
      #1;
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; edge_no = 0; g0 = 0; seen = 1'b0;
      Reset = 1'b1; Shoot1 = 1'b0; Shoot2 = 1'b0;
      Angle1 = 6'd0; Angle2 = 6'd0; Kill = 4'd0;
      tick(); tick();
      check("rst_launch", Launch, 0);
      check("rst_lslot", LaunchSlot, 0);
      check("rst_active", SlotActive, 0);
      check("rst_owner", SlotOwner, 0);
      check("rst_ammo1", Ammo1, 2);
      check("rst_ammo2", Ammo2, 2);
      Reset = 1'b0;
      tick(); tick();

      // single uncontended shot, two-edge latency
      Angle1 = 6'd9; Shoot1 = 1'b1;
      tick();
      check("lat_early", Launch, 0);
      tick();
      check("launch", Launch, 1);
      check("launch_slot", LaunchSlot, 0);
      check("launch_owner", LaunchOwner, 0);
      check("launch_angle", LaunchAngle, 9);
      check("launch_active", SlotActive, 4'b0001);
      check("launch_ammo1", Ammo1, 1);
      check("launch_ammo2", Ammo2, 2);
      tick();
      check("one_pulse", Launch, 0);
      seen = 1'b0;
      repeat (3) begin tick(); seen |= Launch; end
      check("held_once", seen, 0);

      // re-press during cooldown is dropped, not queued
      Shoot1 = 1'b0; tick();
      Shoot1 = 1'b1; tick();
      tick();
      check("cool_drop", Launch, 0);
      Shoot1 = 1'b0;
      seen = 1'b0;
      repeat (30) begin tick(); seen |= Launch; end
      check("no_queue", seen, 0);
      check("cool_active", SlotActive, 4'b0001);

      // kill: idle slot ignored, active slot cleared
      Kill = 4'b0010; tick(); Kill = 4'd0;
      check("kill_idle", SlotActive, 4'b0001);
      Kill = 4'b0001; tick(); Kill = 4'd0;
      check("kill_active", SlotActive, 4'b0000);
      check("kill_ammo1", Ammo1, 2);

      // simultaneous requests with Prio=0
      pulse_reset();
      Angle1 = 6'd5; Angle2 = 6'd33; Shoot1 = 1'b1; Shoot2 = 1'b1;
      tick();
      check("both_early", Launch, 0);
      tick();
      g0 = edge_no;
      check("rr1_launch", Launch, 1);
      check("rr1_owner", LaunchOwner, 0);
      check("rr1_slot", LaunchSlot, 0);
      check("rr1_angle", LaunchAngle, 5);
      tick();
      check("rr2_launch", Launch, 1);
      check("rr2_owner", LaunchOwner, 1);
      check("rr2_slot", LaunchSlot, 1);
      check("rr2_angle", LaunchAngle, 33);
      check("rr2_active", SlotActive, 4'b0011);
      check("rr2_sowner", SlotOwner, 4'b0010);
      check("rr2_ammo1", Ammo1, 1);
      check("rr2_ammo2", Ammo2, 1);
      Shoot1 = 1'b0; Shoot2 = 1'b0;
      repeat (25) tick();
      Shoot1 = 1'b1; Shoot2 = 1'b1;
      tick(); tick();
      check("rr3_owner", LaunchOwner, 0);
      check("rr3_slot", LaunchSlot, 2);
      tick();
      check("rr4_owner", LaunchOwner, 1);
      check("rr4_slot", LaunchSlot, 3);
      check("rr4_active", SlotActive, 4'b1111);
      check("rr4_sowner", SlotOwner, 4'b1010);
      check("rr4_ammo1", Ammo1, 0);
      check("rr4_ammo2", Ammo2, 0);
      Shoot1 = 1'b0; Shoot2 = 1'b0;

      // lifetime expiry exactly 300 edges after the grant
      while (edge_no < g0 + 299) tick();
      check("life_299", SlotActive[0], 1);
      tick();
      check("life_300", SlotActive[0], 0);
      check("life_ammo1", Ammo1, 1);
      tick();
      check("life_slot1", SlotActive[1], 0);
      check("life_ammo2", Ammo2, 1);

      // ammo limit: third shot dropped
      pulse_reset();
      Shoot1 = 1'b1; tick(); tick();
      check("am1_slot", LaunchSlot, 0);
      Shoot1 = 1'b0; repeat (25) tick();
      Shoot1 = 1'b1; tick(); tick();
      check("am2_launch", Launch, 1);
      check("am2_slot", LaunchSlot, 1);
      check("am2_ammo1", Ammo1, 0);
      Shoot1 = 1'b0; repeat (25) tick();
      Shoot1 = 1'b1; tick(); tick();
      check("am3_drop", Launch, 0);
      check("am3_ammo1", Ammo1, 0);
      check("am3_active", SlotActive, 4'b0011);
      Shoot1 = 1'b0;
      Shoot2 = 1'b1; tick(); tick();
      check("t2_slot", LaunchSlot, 2);
      check("t2_owner", LaunchOwner, 1);
      check("t2_active", SlotActive, 4'b0111);

      // async reset mid-flight with Shoot1 held through release
      Shoot2 = 1'b0; Shoot1 = 1'b1;
      Reset = 1'b1;
      #1;
      check("mid_rst_active", SlotActive, 0);
      check("mid_rst_launch", Launch, 0);
      check("mid_rst_ammo1", Ammo1, 2);
      check("mid_rst_ammo2", Ammo2, 2);
      tick(); tick();
      Reset = 1'b0;
      seen = 1'b0;
      repeat (5) begin tick(); seen |= Launch; end
      check("held_thru_rst", seen, 0);
      Shoot1 = 1'b0; tick();
      Shoot1 = 1'b1; tick(); tick();
      check("rearm_launch", Launch, 1);
      check("rearm_slot", LaunchSlot, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bullet_scheduler.md
BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 Parameter LIFETIME, default 10'd300: frames a bullet slot stays active after launch.
REQ-002 Parameter COOLDOWN, default 6'd20: frames a tank must wait after a granted shot before it may be granted again.
REQ-003 Parameter MAX_PER_TANK, default 3'd2: maximum active slots owned by one tank.
REQ-004 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 Shoot1, Shoot2  in  1 each  level shoot request from tank 1 and tank 2.
REQ-007 Angle1, Angle2  in  6 each  current heading index of each tank.
REQ-008 Kill  in  4  per-slot clear request from collision logic.
REQ-009 Launch  out  1  registered one-frame pulse: a bullet is launched.
REQ-010 LaunchSlot  out  2  slot index of the launch; valid while Launch=1.
REQ-011 LaunchOwner  out  1  0=tank 1, 1=tank 2; valid while Launch=1.
REQ-012 LaunchAngle  out  6  winner's Angle sampled at the grant edge; valid while Launch=1.
REQ-013 SlotActive  out  4  per-slot active flag.
REQ-014 SlotOwner  out  4  per-slot owner bit; meaningful only where SlotActive=1.
REQ-015 Ammo1, Ammo2  out  2 each  MAX_PER_TANK minus active slots owned by that tank.

Function
REQ-016 Rising-edge detect per tank: Shoot sampled 1 with previous sample 0 sets that tank's pending flag at that edge; a held Shoot produces exactly one request.
REQ-017 At each edge, a pending tank is eligible iff its cooldown is 0, its owned count is below MAX_PER_TANK, and at least one slot has SlotActive=0.
REQ-018 Exactly one grant per edge at most; if both tanks are eligible, the round-robin pointer Prio picks the winner (Prio=0 -> tank 1).
REQ-019 After any grant, Prio points to the tank not granted; with no grant, Prio holds.
REQ-020 Granted tank: pending cleared, cooldown loaded with COOLDOWN, Launch=1 registered with LaunchSlot, LaunchOwner and LaunchAngle.
REQ-021 Allocated slot = lowest-index slot with SlotActive=0 before the edge; it becomes active, its owner is written, and its lifetime counter is loaded with LIFETIME.
REQ-022 A pending but ineligible tank has its pending flag cleared without launch; requests are never queued beyond one arbitration.
REQ-023 A tank that loses only to contention keeps its pending flag and is re-arbitrated at the next edge.
REQ-024 Latency: Shoot edge sampled at edge k -> Launch high for the cycle after edge k+1 (uncontended, eligible).
REQ-025 Active-slot lifetime counter decrements every edge; an active slot whose counter is 1 clears at that edge (exactly LIFETIME frames active).
REQ-026 Kill[i]=1 on an active slot clears it at the next edge; Kill on an inactive slot is ignored.
REQ-027 A slot cleared by Kill or expiry at edge n is not reallocated before edge n+1.
REQ-028 Cooldown counters decrement by 1 per edge, saturating at 0.
REQ-029 Ammo outputs update at the same edge as slot activation and clearing; never negative.

Reset
REQ-030 On Reset: Launch=0, LaunchSlot=0, LaunchOwner=0, LaunchAngle=0, SlotActive=0, SlotOwner=0, Ammo1=Ammo2=MAX_PER_TANK, pending flags, edge-detect history, cooldowns and lifetimes 0, Prio=0.
REQ-031 Reset asserted mid-flight aborts all bullets; a Shoot held high through reset release does not launch until it falls and rises again.

Verification
REQ-032 Shoot1 rises at edge 5, Angle1=6'd9 -> Launch=1 after edge 6, LaunchSlot=0, LaunchOwner=0, LaunchAngle=9, SlotActive=4'b0001, Ammo1=1.
REQ-033 Shoot1 and Shoot2 rise at the same edge, Prio=0 -> tank 1 gets slot 0 at the next edge; tank 2 gets slot 1 one edge later, Prio=0 again.
REQ-034 Tank 1 fires twice, COOLDOWN apart, then a third time -> third request dropped, no Launch, Ammo1=0.
REQ-035 Second Shoot1 edge 5 frames after a grant (COOLDOWN=20) -> no Launch, pending cleared.
REQ-036 Slot 0 launched, Kill=4'b0001 at frame 10 -> SlotActive[0]=0 next edge; unkilled slot clears exactly 300 frames after launch.
REQ-037 Reset pulsed with 3 slots active -> SlotActive=0, Ammo1=Ammo2=2 immediately, no Launch while Shoot held high.
